// File: rtl/matmul_scheduler_module.sv
// -----------------------------------------------------------------------------
// matmul_scheduler_module
//
// Walks the output matrix C = A x B one element at a time, in row-major order.
// For every element C(i,j) the block presents the A-row / B-row / C-element
// addresses, waits PIPE_LAT cycles for the external MAC pipeline, and then
// strobes the scratchpad write. The scratchpad write can be deferred by the
// bus through hold_i.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   start_bit_i    start bit from the control register (level; rising edge starts)
//   n_dim_i        rows of A minus one
//   k_dim_i        inner dimension minus one (latched for the datapath only)
//   m_dim_i        columns of B minus one
//   hold_i         bus owns the scratchpad write port this cycle
//   address_a_o    A row address, row index in bits [5 +: IDX_W]
//   address_b_o    B row address, column index in bits [5 +: IDX_W]
//   address_c_o    C element address, i*MAX_DIM+j in bits [5 +: 2*IDX_W]
//   sp_enable_o    scratchpad write strobe for C(i,j)
//   busy_o         sequence in progress
//   done_o         one-cycle completion pulse
//   clear_start_o  one-cycle request to clear the control start bit
// -----------------------------------------------------------------------------
module matmul_scheduler_module #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_bit_i,
  input  logic [1:0]            n_dim_i,
  input  logic [1:0]            k_dim_i,
  input  logic [1:0]            m_dim_i,
  input  logic                  hold_i,
  output logic [ADDR_WIDTH-1:0] address_a_o,
  output logic [ADDR_WIDTH-1:0] address_b_o,
  output logic [ADDR_WIDTH-1:0] address_c_o,
  output logic                  sp_enable_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  clear_start_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int IDX_W   = $clog2(MAX_DIM);
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_nxt;
  logic [IDX_W-1:0]  i_q, i_nxt;
  logic [IDX_W-1:0]  j_q, j_nxt;
  logic [IDX_W-1:0]  n_q, m_q, k_q;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              start_hist_q;
  logic              start_edge;
  logic              active_nxt;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q, addr_c_q;

  // k is only consumed by the external datapath; nothing here reads it.
  logic unused_k;
  assign unused_k = ^k_q;

  // Oversized dimensions saturate to the largest index the bus can carry.
  function automatic logic [IDX_W-1:0] clamp_dim(input logic [1:0] dim);
    int d;
    d = int'({30'd0, dim});
    if (d > MAX_DIM - 1) d = MAX_DIM - 1;
    return d[IDX_W-1:0];
  endfunction

  // Index field placed at bit 5; every other address bit stays zero.
  function automatic logic [ADDR_WIDTH-1:0] field_addr(input int val);
    return ADDR_WIDTH'(val) << 5;
  endfunction

  assign start_edge = start_bit_i & ~start_hist_q;

  always_comb begin
    state_nxt = state_q;
    i_nxt     = i_q;
    j_nxt     = j_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_nxt = FETCH;
          i_nxt     = '0;
          j_nxt     = '0;
        end
      end
      FETCH: begin
        state_nxt = CALC;
        cnt_nxt   = CNT_W'(PIPE_LAT - 1);
      end
      CALC: begin
        if (cnt_q == '0) state_nxt = WRITE;
        else             cnt_nxt   = cnt_q - CNT_W'(1);
      end
      WRITE: begin
        // A held write keeps i/j, so the addresses stay put.
        if (!hold_i) begin
          if (j_q < m_q) begin
            j_nxt     = j_q + IDX_W'(1);
            state_nxt = FETCH;
          end else if (i_q < n_q) begin
            i_nxt     = i_q + IDX_W'(1);
            j_nxt     = '0;
            state_nxt = FETCH;
          end else begin
            i_nxt     = '0;
            j_nxt     = '0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign active_nxt = (state_nxt == FETCH) || (state_nxt == CALC) || (state_nxt == WRITE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      cnt_q        <= '0;
      start_hist_q <= 1'b1;
      n_q          <= '0;
      m_q          <= '0;
      k_q          <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      addr_c_q     <= '0;
    end else begin
      state_q      <= state_nxt;
      i_q          <= i_nxt;
      j_q          <= j_nxt;
      cnt_q        <= cnt_nxt;
      start_hist_q <= start_bit_i;
      if (state_q == IDLE && start_edge) begin
        n_q <= clamp_dim(n_dim_i);
        m_q <= clamp_dim(m_dim_i);
        k_q <= clamp_dim(k_dim_i);
      end
      // Addresses are registered from the next indices so they are valid
      // from the first FETCH cycle and zero in IDLE/DONE.
      if (active_nxt) begin
        addr_a_q <= field_addr(int'(32'(i_nxt)));
        addr_b_q <= field_addr(int'(32'(j_nxt)));
        addr_c_q <= field_addr(int'(32'(i_nxt)) * MAX_DIM + int'(32'(j_nxt)));
      end else begin
        addr_a_q <= '0;
        addr_b_q <= '0;
        addr_c_q <= '0;
      end
    end
  end

  assign address_a_o   = addr_a_q;
  assign address_b_o   = addr_b_q;
  assign address_c_o   = addr_c_q;
  assign sp_enable_o   = (state_q == WRITE) && !hold_i;
  assign busy_o        = (state_q == FETCH) || (state_q == CALC) || (state_q == WRITE);
  assign done_o        = (state_q == DONE);
  assign clear_start_o = (state_q == DONE);

endmodule

// File: tb/tb_matmul_scheduler_module.sv
// -----------------------------------------------------------------------------
// tb_matmul_scheduler_module
//
// Bench for matmul_scheduler_module with default parameters. Expected
// per-cycle outputs come from a schedule model: each element occupies
// FETCH (1) + CALC (PIPE_LAT) cycles, then its write lands on the first
// following cycle with hold low; DONE follows the last write.
// Cycle 0 is the cycle in which start_bit_i first reads high.
// -----------------------------------------------------------------------------
module tb_matmul_scheduler_module;

  localparam int ADDR_WIDTH = 32;
  localparam int MAXD       = 2;
  localparam int PL         = 2;
  localparam int W          = 60;

  logic                  clk_i;
  logic                  rst_i;
  logic                  start_bit_i;
  logic [1:0]            n_dim_i;
  logic [1:0]            k_dim_i;
  logic [1:0]            m_dim_i;
  logic                  hold_i;
  logic [ADDR_WIDTH-1:0] address_a_o;
  logic [ADDR_WIDTH-1:0] address_b_o;
  logic [ADDR_WIDTH-1:0] address_c_o;
  logic                  sp_enable_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  clear_start_o;

  int total;
  int bad;

  matmul_scheduler_module dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_bit_i  (start_bit_i),
    .n_dim_i      (n_dim_i),
    .k_dim_i      (k_dim_i),
    .m_dim_i      (m_dim_i),
    .hold_i       (hold_i),
    .address_a_o  (address_a_o),
    .address_b_o  (address_b_o),
    .address_c_o  (address_c_o),
    .sp_enable_o  (sp_enable_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .clear_start_o(clear_start_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_all(input int c, input bit e_sp, input bit e_busy, input bit e_done,
                           input logic [31:0] e_a, input logic [31:0] e_b, input logic [31:0] e_c);
    chk("sp_enable",   c, 64'(sp_enable_o),   64'(e_sp));
    chk("busy",        c, 64'(busy_o),        64'(e_busy));
    chk("done",        c, 64'(done_o),        64'(e_done));
    chk("clear_start", c, 64'(clear_start_o), 64'(e_done));
    chk("address_a",   c, 64'(address_a_o),   64'(e_a));
    chk("address_b",   c, 64'(address_b_o),   64'(e_b));
    chk("address_c",   c, 64'(address_c_o),   64'(e_c));
  endtask

  // hold_mode: 0 = no hold, 1 = hold on cycles 4..6, 2 = random holds.
  // toggle: drop start on cycle 2 and raise it on cycle 3 (edge while busy).
  task automatic run_seq(input int n_in, input int m_in, input int hold_mode, input bit toggle);
    bit hold_arr[W];
    bit e_sp[W];
    bit e_busy[W];
    bit e_done[W];
    bit e_act[W];
    int e_i[W];
    int e_j[W];
    int n_c, m_c, t, w;
    logic [1:0] n_drv, m_drv;
    for (int c = 0; c < W; c++) begin
      hold_arr[c] = 1'b0; e_sp[c] = 1'b0; e_busy[c] = 1'b0;
      e_done[c] = 1'b0; e_act[c] = 1'b0; e_i[c] = 0; e_j[c] = 0;
    end
    if (hold_mode == 1) begin
      hold_arr[4] = 1'b1; hold_arr[5] = 1'b1; hold_arr[6] = 1'b1;
    end else if (hold_mode == 2) begin
      for (int c = 0; c < 30; c++) hold_arr[c] = ($urandom_range(0, 3) == 0);
    end
    n_c = (n_in > MAXD - 1) ? MAXD - 1 : n_in;
    m_c = (m_in > MAXD - 1) ? MAXD - 1 : m_in;
    t = 1;
    for (int i = 0; i <= n_c; i++) begin
      for (int j = 0; j <= m_c; j++) begin
        w = t + 1 + PL;
        while (hold_arr[w]) w++;
        for (int c = t; c <= w; c++) begin
          e_busy[c] = 1'b1; e_act[c] = 1'b1; e_i[c] = i; e_j[c] = j;
        end
        e_sp[w] = 1'b1;
        t = w + 1;
      end
    end
    e_done[t] = 1'b1;

    n_drv = n_in[1:0];
    m_drv = m_in[1:0];
    @(posedge clk_i); #1;
    start_bit_i = 1'b0;
    n_dim_i     = n_drv;
    m_dim_i     = m_drv;
    k_dim_i     = 2'($urandom);
    hold_i      = 1'b0;
    @(posedge clk_i); #1;
    start_bit_i = 1'b1;
    for (int c = 0; c < W; c++) begin
      if (c > 0) begin
        @(posedge clk_i); #1;
      end
      hold_i = hold_arr[c];
      if (c == 1) begin
        n_dim_i = 2'($urandom);
        m_dim_i = 2'($urandom);
        k_dim_i = 2'($urandom);
      end
      if (toggle && c == 2) start_bit_i = 1'b0;
      if (toggle && c == 3) start_bit_i = 1'b1;
      @(negedge clk_i);
      check_all(c, e_sp[c], e_busy[c], e_done[c],
                e_act[c] ? 32'(e_i[c] * 32) : 32'd0,
                e_act[c] ? 32'(e_j[c] * 32) : 32'd0,
                e_act[c] ? 32'((e_i[c] * MAXD + e_j[c]) * 32) : 32'd0);
    end
    hold_i = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_i       = 1'b1;
    start_bit_i = 1'b1;
    n_dim_i     = 2'd1;
    k_dim_i     = 2'd1;
    m_dim_i     = 2'd1;
    hold_i      = 1'b0;

    // Reset with start already high: outputs zero, and no launch afterwards.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all(-1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check_all(100 + c, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      @(posedge clk_i); #1;
    end

    // Nominal 2x2, start held high through DONE and beyond.
    run_seq(1, 1, 0, 1'b0);
    // Single element.
    run_seq(0, 0, 0, 1'b0);
    // Three-cycle hold at the first write.
    run_seq(1, 1, 1, 1'b0);
    // Oversized n clamps to MAX_DIM-1; start edge while busy is ignored.
    run_seq(3, 1, 0, 1'b1);

    // Reset during CALC of element (1,0).
    @(posedge clk_i); #1;
    start_bit_i = 1'b0;
    n_dim_i     = 2'd1;
    m_dim_i     = 2'd1;
    @(posedge clk_i); #1;
    start_bit_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check_all(10, 1'b0, 1'b1, 1'b0, 32'd32, 32'd0, 32'd64);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      check_all(200 + c, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      @(posedge clk_i); #1;
    end
    // Fresh start after the abort runs the full schedule.
    run_seq(1, 1, 0, 1'b0);

    // Randomized dimensions, holds and spurious start edges.
    for (int r = 0; r < 8; r++) begin
      run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2,
              1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
